// File: rtl/stdp_fanin_neuron.sv
// Leaky integrate-and-fire neuron with N_IN plastic synapses, pair-based STDP,
// a refractory period, saturating arithmetic and a host weight-load port.
module stdp_fanin_neuron #(
    parameter  int N_IN        = 4,
    parameter  int W_WIDTH     = 8,
    parameter  int V_WIDTH     = 10,
    parameter  int THRESHOLD   = 60,
    parameter  int LEAK        = 1,
    parameter  int W_INIT      = 30,
    parameter  int LTP_STEP    = 2,
    parameter  int LTD_STEP    = 1,
    parameter  int TRACE_WIDTH = 4,
    parameter  int TRACE_MAX   = 8,
    parameter  int REFRACT     = 2,
    localparam int IDX_W       = (N_IN > 1) ? $clog2(N_IN) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      learn_en,
    input  logic [N_IN-1:0]           spike_in,
    input  logic                      w_wr_en,
    input  logic [IDX_W-1:0]          w_wr_idx,
    input  logic [W_WIDTH-1:0]        w_wr_data,
    output logic                      spike_out,
    output logic [V_WIDTH-1:0]        v_mem,
    output logic [N_IN*W_WIDTH-1:0]   weights
);

    localparam int SUM_W = W_WIDTH + $clog2(N_IN);
    localparam int EXT_W = ((V_WIDTH > SUM_W) ? V_WIDTH : SUM_W) + 1;
    localparam int RC_W  = (REFRACT > 0) ? $clog2(REFRACT + 1) : 1;

    localparam logic [V_WIDTH-1:0]     V_MAX    = '1;
    localparam logic [V_WIDTH-1:0]     LEAK_V   = V_WIDTH'(LEAK);
    localparam logic [V_WIDTH-1:0]     THRESH_V = V_WIDTH'(THRESHOLD);
    localparam logic [W_WIDTH-1:0]     W_MAX    = '1;
    localparam logic [W_WIDTH-1:0]     W_INIT_W = W_WIDTH'(W_INIT);
    localparam logic [W_WIDTH-1:0]     LTP_W    = W_WIDTH'(LTP_STEP);
    localparam logic [W_WIDTH-1:0]     LTD_W    = W_WIDTH'(LTD_STEP);
    localparam logic [TRACE_WIDTH-1:0] TR_MAX   = TRACE_WIDTH'(TRACE_MAX);
    localparam logic [RC_W-1:0]        REFR_C   = RC_W'(REFRACT);

    logic [V_WIDTH-1:0]     r_v;
    logic                   r_spike;
    logic [RC_W-1:0]        r_refr;
    logic [TRACE_WIDTH-1:0] r_post;
    logic [TRACE_WIDTH-1:0] r_pre [N_IN];
    logic [W_WIDTH-1:0]     r_w   [N_IN];
    logic [N_IN-1:0]        r_prev;

    logic [SUM_W-1:0]       w_i_sum;
    logic [EXT_W-1:0]       w_v_ext;
    logic [V_WIDTH-1:0]     w_v_sum;
    logic [V_WIDTH-1:0]     w_v_next;
    logic                   w_fire;
    logic [N_IN-1:0]        w_pre_nz;
    logic [N_IN-1:0]        w_rise;
    logic [N_IN-1:0]        w_ltp;
    logic [N_IN-1:0]        w_ltd;
    logic [W_WIDTH-1:0]     w_w_next [N_IN];

    // NOTE: every always_comb variable gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        w_i_sum  = '0;
        w_pre_nz = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (spike_in[i]) w_i_sum = w_i_sum + SUM_W'(r_w[i]);
            w_pre_nz[i] = (r_pre[i] != '0);
        end
    end

    // Widened add so the clamp to V_MAX sees the true sum.
    assign w_v_ext  = EXT_W'(r_v) + EXT_W'(w_i_sum);
    assign w_v_sum  = (w_v_ext > EXT_W'(V_MAX)) ? V_MAX : w_v_ext[V_WIDTH-1:0];
    assign w_v_next = (w_v_sum >= LEAK_V) ? (w_v_sum - LEAK_V) : '0;
    assign w_fire   = (r_refr == '0) && (w_v_next >= THRESH_V);

    assign w_rise = spike_in & ~r_prev;
    assign w_ltp  = (learn_en && w_fire) ? (spike_in | w_pre_nz) : '0;
    assign w_ltd  = (learn_en && !w_fire && (r_post != '0)) ? w_rise : '0;

    // Priority per weight: host write, then LTP, then LTD.
    always_comb begin
        for (int i = 0; i < N_IN; i++) begin
            w_w_next[i] = r_w[i];
            if (w_ltp[i])
                w_w_next[i] = ((W_MAX - r_w[i]) < LTP_W) ? W_MAX : (r_w[i] + LTP_W);
            else if (w_ltd[i])
                w_w_next[i] = (r_w[i] < LTD_W) ? '0 : (r_w[i] - LTD_W);
            if (w_wr_en && (int'(w_wr_idx) == i))
                w_w_next[i] = w_wr_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_v     <= '0;
            r_spike <= 1'b0;
            r_refr  <= '0;
            r_post  <= '0;
            r_prev  <= '0;
            // NOTE: the weight array is reset deliberately; learned weights must return to W_INIT.
            for (int i = 0; i < N_IN; i++) begin
                r_pre[i] <= '0;
                r_w[i]   <= W_INIT_W;
            end
        end else begin
            r_prev <= spike_in;
            for (int i = 0; i < N_IN; i++) begin
                r_w[i]   <= w_w_next[i];
                r_pre[i] <= spike_in[i] ? TR_MAX :
                            (w_pre_nz[i] ? (r_pre[i] - TRACE_WIDTH'(1)) : '0);
            end
            r_post <= w_fire ? TR_MAX :
                      ((r_post != '0) ? (r_post - TRACE_WIDTH'(1)) : '0);

            if (r_refr != '0) begin
                r_v     <= '0;
                r_refr  <= r_refr - RC_W'(1);
                r_spike <= 1'b0;
            end else if (w_fire) begin
                r_v     <= '0;
                r_refr  <= REFR_C;
                r_spike <= 1'b1;
            end else begin
                r_v     <= w_v_next;
                r_spike <= 1'b0;
            end
        end
    end

    assign spike_out = r_spike;
    assign v_mem     = r_v;

    always_comb begin
        weights = '0;
        for (int i = 0; i < N_IN; i++)
            weights[i*W_WIDTH +: W_WIDTH] = r_w[i];
    end

endmodule

// File: tb/tb_stdp_fanin_neuron.sv
// Scoreboard bench for stdp_fanin_neuron: each stimulus cycle queues its hand-computed
// expected outputs, and a monitor compares them one time step after the edge.
module tb_stdp_fanin_neuron;

    logic        clk = 1'b0;
    logic        rst;
    logic        learn_en;
    logic [3:0]  spike_in;
    logic        w_wr_en;
    logic [1:0]  w_wr_idx;
    logic [7:0]  w_wr_data;
    logic        spike_out;
    logic [9:0]  v_mem;
    logic [31:0] weights;

    stdp_fanin_neuron dut (
        .clk       (clk),
        .rst       (rst),
        .learn_en  (learn_en),
        .spike_in  (spike_in),
        .w_wr_en   (w_wr_en),
        .w_wr_idx  (w_wr_idx),
        .w_wr_data (w_wr_data),
        .spike_out (spike_out),
        .v_mem     (v_mem),
        .weights   (weights)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        spk;
        bit          chk_v;
        logic [9:0]  v;
        bit          chk_w;
        logic [31:0] w;
    } exp_t;

    exp_t sb_q[$];
    exp_t m_e;
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Monitor: outputs for the edge just taken are compared 1 time unit later.
    always @(posedge clk) begin
        #1;
        if (sb_q.size() > 0) begin
            m_e = sb_q.pop_front();
            check({m_e.name, " spike_out"}, 32'(spike_out), 32'(m_e.spk));
            if (m_e.chk_v) check({m_e.name, " v_mem"}, 32'(v_mem), 32'(m_e.v));
            if (m_e.chk_w) check({m_e.name, " weights"}, weights, m_e.w);
        end
    end

    // One clock cycle of stimulus plus the expectation for the edge that samples it.
    task automatic cyc(input string nm, input logic r, input logic le, input logic [3:0] sp,
                       input logic we, input logic [1:0] wi, input logic [7:0] wd,
                       input logic es, input bit cv, input logic [9:0] ev,
                       input bit cw, input logic [31:0] ew);
        exp_t e;
        @(posedge clk);
        #2;
        rst       = r;
        learn_en  = le;
        spike_in  = sp;
        w_wr_en   = we;
        w_wr_idx  = wi;
        w_wr_data = wd;
        e.name  = nm;
        e.spk   = es;
        e.chk_v = cv;
        e.v     = ev;
        e.chk_w = cw;
        e.w     = ew;
        sb_q.push_back(e);
    endtask

    localparam logic [31:0] W_ALL30 = 32'h1E1E1E1E;

    initial begin
        rst = 1'b1; learn_en = 1'b0; spike_in = '0;
        w_wr_en = 1'b0; w_wr_idx = '0; w_wr_data = '0;

        // Reset dominates spikes and host writes.
        cyc("rst0", 1, 1, 4'hF, 1, 2'd0, 8'd99, 0, 1, 10'd0, 1, W_ALL30);
        cyc("rst1", 1, 1, 4'hF, 1, 2'd1, 8'd99, 0, 1, 10'd0, 1, W_ALL30);

        // Integration and refractory, learning off.
        cyc("int_e1", 0, 0, 4'b0001, 0, 0, 0, 0, 1, 10'd29, 1, W_ALL30);
        cyc("int_e2", 0, 0, 4'b0001, 0, 0, 0, 0, 1, 10'd58, 1, W_ALL30);
        cyc("int_e3", 0, 0, 4'b0001, 0, 0, 0, 1, 1, 10'd0,  1, W_ALL30);
        cyc("int_e4", 0, 0, 4'b0001, 0, 0, 0, 0, 1, 10'd0,  1, W_ALL30);
        cyc("int_e5", 0, 0, 4'b0001, 0, 0, 0, 0, 1, 10'd0,  1, W_ALL30);
        cyc("int_e6", 0, 0, 4'b0001, 0, 0, 0, 0, 1, 10'd29, 1, W_ALL30);

        // LTP with continuous input, then reset during refractory.
        cyc("ltp_rst", 1, 0, 4'b0000, 0, 0, 0, 0, 1, 10'd0, 1, W_ALL30);
        cyc("ltp_e1", 0, 1, 4'b0001, 0, 0, 0, 0, 1, 10'd29, 1, W_ALL30);
        cyc("ltp_e2", 0, 1, 4'b0001, 0, 0, 0, 0, 1, 10'd58, 1, W_ALL30);
        cyc("ltp_e3", 0, 1, 4'b0001, 0, 0, 0, 1, 1, 10'd0,  1, 32'h1E1E1E20);
        cyc("ltp_e4", 0, 1, 4'b0001, 0, 0, 0, 0, 1, 10'd0,  1, 32'h1E1E1E20);
        cyc("ltp_e5", 0, 1, 4'b0001, 0, 0, 0, 0, 1, 10'd0,  1, 32'h1E1E1E20);
        cyc("ltp_e6", 0, 1, 4'b0001, 0, 0, 0, 0, 1, 10'd31, 1, 32'h1E1E1E20);
        cyc("ltp_e7", 0, 1, 4'b0001, 0, 0, 0, 1, 1, 10'd0,  1, 32'h1E1E1E22);
        cyc("mid_rst", 1, 1, 4'b0001, 0, 0, 0, 0, 1, 10'd0, 1, W_ALL30);
        cyc("post_e1", 0, 0, 4'b0001, 0, 0, 0, 0, 1, 10'd29, 1, W_ALL30);
        cyc("post_e2", 0, 0, 4'b0001, 0, 0, 0, 0, 1, 10'd58, 1, W_ALL30);
        cyc("post_e3", 0, 0, 4'b0001, 0, 0, 0, 1, 1, 10'd0,  1, W_ALL30);

        // LTD window.
        cyc("ltd_rst", 1, 0, 4'b0000, 0, 0, 0, 0, 1, 10'd0, 1, W_ALL30);
        cyc("ltd_e1", 0, 1, 4'b0011, 0, 0, 0, 0, 1, 10'd59, 1, W_ALL30);
        cyc("ltd_e2", 0, 1, 4'b0011, 0, 0, 0, 1, 1, 10'd0,  1, 32'h1E1E2020);
        cyc("ltd_e3", 0, 1, 4'b0000, 0, 0, 0, 0, 1, 10'd0,  1, 32'h1E1E2020);
        cyc("ltd_e4", 0, 1, 4'b0000, 0, 0, 0, 0, 1, 10'd0,  1, 32'h1E1E2020);
        cyc("ltd_e5", 0, 1, 4'b0100, 0, 0, 0, 0, 1, 10'd29, 1, 32'h1E1D2020);
        for (int k = 0; k < 10; k++)
            cyc($sformatf("ltd_idle%0d", k), 0, 1, 4'b0000, 0, 0, 0, 0,
                1, 10'(28 - k), 1, 32'h1E1D2020);
        cyc("ltd_late", 0, 1, 4'b1000, 0, 0, 0, 0, 1, 10'd48, 1, 32'h1E1D2020);

        // Weight saturation and host-write priority.
        cyc("sat_rst", 1, 0, 4'b0000, 0, 0, 0, 0, 1, 10'd0, 1, W_ALL30);
        cyc("sat_wr254", 0, 1, 4'b0000, 1, 2'd0, 8'd254, 0, 1, 10'd0, 1, 32'h1E1E1EFE);
        cyc("sat_fire",  0, 1, 4'b0001, 0, 0, 0,          1, 1, 10'd0, 1, 32'h1E1E1EFF);
        cyc("sat_wr0",   0, 1, 4'b0000, 1, 2'd3, 8'd0,    0, 1, 10'd0, 1, 32'h001E1EFF);
        cyc("sat_ltd0",  0, 1, 4'b1000, 0, 0, 0,          0, 1, 10'd0, 1, 32'h001E1EFF);
        cyc("wr_on_fire", 0, 1, 4'b0001, 1, 2'd0, 8'd100, 1, 1, 10'd0, 1, 32'h021E1E64);

        // Membrane clamp: 6 + 1020 must saturate rather than wrap.
        cyc("clamp_rst", 1, 0, 4'b0000, 0, 0, 0, 0, 1, 10'd0, 1, W_ALL30);
        cyc("clamp_w0",  0, 0, 4'b0000, 1, 2'd0, 8'd11,  0, 1, 10'd0,  1, 32'h1E1E1E0B);
        cyc("clamp_v10", 0, 0, 4'b0001, 0, 0, 0,         0, 1, 10'd10, 1, 32'h1E1E1E0B);
        cyc("clamp_wa",  0, 0, 4'b0000, 1, 2'd0, 8'd255, 0, 1, 10'd9,  1, 32'h1E1E1EFF);
        cyc("clamp_wb",  0, 0, 4'b0000, 1, 2'd1, 8'd255, 0, 1, 10'd8,  1, 32'h1E1EFFFF);
        cyc("clamp_wc",  0, 0, 4'b0000, 1, 2'd2, 8'd255, 0, 1, 10'd7,  1, 32'h1EFFFFFF);
        cyc("clamp_wd",  0, 0, 4'b0000, 1, 2'd3, 8'd255, 0, 1, 10'd6,  1, 32'hFFFFFFFF);
        cyc("clamp_fire", 0, 0, 4'b1111, 0, 0, 0,       1, 1, 10'd0,  1, 32'hFFFFFFFF);

        @(posedge clk);
        #2;
        spike_in = '0;
        repeat (2) @(posedge clk);
        #3;
        check("scoreboard drained", 32'(sb_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
